// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, opcodes, the ALU
// command encoding (must match the ALU's decoder), instruction classes and
// the ID/EXE pipeline bundle. Ports: none (package).
package cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;
  typedef logic [3:0]  exe_cmd_t;
  typedef logic [5:0]  opcode_t;

  // Instruction field bit positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RD_MSB  = 25;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS1_MSB = 20;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_MSB = 15;
  localparam int unsigned RS2_LSB = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  // Opcodes
  localparam opcode_t OP_NOP  = 6'd0;
  localparam opcode_t OP_ADD  = 6'd1;
  localparam opcode_t OP_SUB  = 6'd3;
  localparam opcode_t OP_AND  = 6'd5;
  localparam opcode_t OP_OR   = 6'd6;
  localparam opcode_t OP_NOR  = 6'd7;
  localparam opcode_t OP_XOR  = 6'd8;
  localparam opcode_t OP_SLA  = 6'd9;
  localparam opcode_t OP_SLL  = 6'd10;
  localparam opcode_t OP_SRA  = 6'd11;
  localparam opcode_t OP_SRL  = 6'd12;
  localparam opcode_t OP_ADDI = 6'd32;
  localparam opcode_t OP_SUBI = 6'd33;
  localparam opcode_t OP_LD   = 6'd36;
  localparam opcode_t OP_ST   = 6'd37;
  localparam opcode_t OP_BEZ  = 6'd40;
  localparam opcode_t OP_BNE  = 6'd41;
  localparam opcode_t OP_JMP  = 6'd42;

  // ALU command encodings
  localparam exe_cmd_t EXE_ADD = 4'd0;
  localparam exe_cmd_t EXE_SUB = 4'd1;
  localparam exe_cmd_t EXE_AND = 4'd2;
  localparam exe_cmd_t EXE_OR  = 4'd3;
  localparam exe_cmd_t EXE_NOR = 4'd4;
  localparam exe_cmd_t EXE_XOR = 4'd5;
  localparam exe_cmd_t EXE_SLA = 4'd6;
  localparam exe_cmd_t EXE_SLL = 4'd7;
  localparam exe_cmd_t EXE_SRL = 4'd8;
  localparam exe_cmd_t EXE_SRA = 4'd9;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_BEZ, CLS_BNE, CLS_JMP
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    exe_cmd_t     cmd;
  } decode_t;

  // ID/EXE pipeline register contents; all-zero is a bubble
  typedef struct packed {
    exe_cmd_t cmd;
    word_t    val1;
    word_t    val2;
    word_t    st_val;
    reg_idx_t dest;
    logic     wb_en;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     is_branch;
    logic     valid;
  } id_exe_t;

  function automatic decode_t decode_opcode(input opcode_t op);
    decode_t d;
    d.cls = CLS_NOP;
    d.cmd = EXE_ADD;
    case (op)
      OP_ADD:  begin d.cls = CLS_R;   d.cmd = EXE_ADD; end
      OP_SUB:  begin d.cls = CLS_R;   d.cmd = EXE_SUB; end
      OP_AND:  begin d.cls = CLS_R;   d.cmd = EXE_AND; end
      OP_OR:   begin d.cls = CLS_R;   d.cmd = EXE_OR;  end
      OP_NOR:  begin d.cls = CLS_R;   d.cmd = EXE_NOR; end
      OP_XOR:  begin d.cls = CLS_R;   d.cmd = EXE_XOR; end
      OP_SLA:  begin d.cls = CLS_R;   d.cmd = EXE_SLA; end
      OP_SLL:  begin d.cls = CLS_R;   d.cmd = EXE_SLL; end
      OP_SRA:  begin d.cls = CLS_R;   d.cmd = EXE_SRA; end
      OP_SRL:  begin d.cls = CLS_R;   d.cmd = EXE_SRL; end
      OP_ADDI: begin d.cls = CLS_I;   d.cmd = EXE_ADD; end
      OP_SUBI: begin d.cls = CLS_I;   d.cmd = EXE_SUB; end
      OP_LD:   d.cls = CLS_LD;
      OP_ST:   d.cls = CLS_ST;
      OP_BEZ:  d.cls = CLS_BEZ;
      OP_BNE:  d.cls = CLS_BNE;
      OP_JMP:  d.cls = CLS_JMP;
      default: d.cls = CLS_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch/writeback/forwarding-tag inputs toward the decode
// stage and the registered ID/EXE bundle plus hazard_stall back out.
// master: pipeline side driving the decode stage; slave: the decode stage.
interface id_stage_if;
  import cpu_pkg::*;

  logic     instr_valid;
  word_t    instr;
  logic     flush;
  logic     wb_en;
  reg_idx_t wb_dest;
  word_t    wb_value;
  reg_idx_t exe_dest;
  logic     exe_wb_en;
  reg_idx_t mem_dest;
  logic     mem_wb_en;

  logic     hazard_stall;
  exe_cmd_t EXE_CMD;
  word_t    val1;
  word_t    val2;
  word_t    st_val;
  reg_idx_t dest;
  logic     WB_EN;
  logic     MEM_R_EN;
  logic     MEM_W_EN;
  logic     is_branch;
  logic     exe_valid;

  modport master (
    output instr_valid, instr, flush, wb_en, wb_dest, wb_value,
           exe_dest, exe_wb_en, mem_dest, mem_wb_en,
    input  hazard_stall, EXE_CMD, val1, val2, st_val, dest,
           WB_EN, MEM_R_EN, MEM_W_EN, is_branch, exe_valid
  );

  modport slave (
    input  instr_valid, instr, flush, wb_en, wb_dest, wb_value,
           exe_dest, exe_wb_en, mem_dest, mem_wb_en,
    output hazard_stall, EXE_CMD, val1, val2, st_val, dest,
           WB_EN, MEM_R_EN, MEM_W_EN, is_branch, exe_valid
  );
endinterface

// File: rtl/register_file.sv
// 32 x 32 register file: two asynchronous read ports, one synchronous write
// port, R0 reads as zero, and a same-cycle write is bypassed to the readers.
// Ports: clk; ra_addr/ra_data, rb_addr/rb_data (read); we/w_addr/w_data (write).
module register_file
  import cpu_pkg::*;
(
  input  logic     clk,
  input  reg_idx_t ra_addr,
  output word_t    ra_data,
  input  reg_idx_t rb_addr,
  output word_t    rb_data,
  input  logic     we,
  input  reg_idx_t w_addr,
  input  word_t    w_data
);

  word_t regs [32];

  always_ff @(posedge clk) begin
    if (we && (w_addr != '0)) begin
      regs[w_addr] <= w_data;
    end
  end

  always_comb begin
    ra_data = regs[ra_addr];
    if (ra_addr == '0) begin
      ra_data = '0;
    end else if (we && (w_addr == ra_addr)) begin
      ra_data = w_data;
    end
  end

  always_comb begin
    rb_data = regs[rb_addr];
    if (rb_addr == '0) begin
      rb_data = '0;
    end else if (we && (w_addr == rb_addr)) begin
      rb_data = w_data;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: reads operands, decodes the opcode into the ALU
// command and controls, detects RAW hazards against EXE/MEM destinations and
// loads the ID/EXE register (bubble on reset, flush, stall or no instruction).
// Ports: clk, rst (sync, active high); bus (id_stage_if.slave).
module id_stage
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  opcode_t  opcode;
  reg_idx_t rd, rs1, rs2;
  word_t    imm_sext;
  decode_t  dec;

  assign opcode   = bus.instr[OPC_MSB:OPC_LSB];
  assign rd       = bus.instr[RD_MSB:RD_LSB];
  assign rs1      = bus.instr[RS1_MSB:RS1_LSB];
  assign rs2      = bus.instr[RS2_MSB:RS2_LSB];
  assign imm_sext = {{16{bus.instr[IMM_MSB]}}, bus.instr[IMM_MSB:IMM_LSB]};
  assign dec      = decode_opcode(opcode);

  // Port B serves rs2 for R-type and rd for ST/BNE
  logic     use_a, use_b;
  reg_idx_t addr_b;
  word_t    rdata_a, rdata_b;

  always_comb begin
    use_a  = 1'b0;
    use_b  = 1'b0;
    addr_b = rs2;
    case (dec.cls)
      CLS_R:                  begin use_a = 1'b1; use_b = 1'b1; end
      CLS_I, CLS_LD, CLS_BEZ: use_a = 1'b1;
      CLS_ST, CLS_BNE:        begin use_a = 1'b1; use_b = 1'b1; addr_b = rd; end
      default:                ;
    endcase
  end

  register_file u_rf (
    .clk     (clk),
    .ra_addr (rs1),
    .ra_data (rdata_a),
    .rb_addr (addr_b),
    .rb_data (rdata_b),
    .we      (bus.wb_en),
    .w_addr  (bus.wb_dest),
    .w_data  (bus.wb_value)
  );

  logic hit_a, hit_b, hazard;

  always_comb begin
    hit_a = use_a && (rs1 != '0) &&
            ((bus.exe_wb_en && (bus.exe_dest == rs1)) ||
             (bus.mem_wb_en && (bus.mem_dest == rs1)));
    hit_b = use_b && (addr_b != '0) &&
            ((bus.exe_wb_en && (bus.exe_dest == addr_b)) ||
             (bus.mem_wb_en && (bus.mem_dest == addr_b)));
    // Flush and reset both mask the stall so fetch is never held by a
    // squashed or reset instruction.
    hazard = !rst && bus.instr_valid && !bus.flush && (hit_a || hit_b);
  end

  assign bus.hazard_stall = hazard;

  id_exe_t nxt, q;

  always_comb begin
    nxt = '0;
    if (dec.cls != CLS_NOP) begin
      nxt.valid = 1'b1;
      nxt.cmd   = dec.cmd;
      nxt.val1  = rdata_a;
      nxt.val2  = imm_sext;
      nxt.dest  = rd;
      case (dec.cls)
        CLS_R:   begin nxt.val2 = rdata_b; nxt.wb_en = 1'b1; end
        CLS_I:   nxt.wb_en = 1'b1;
        CLS_LD:  begin nxt.wb_en = 1'b1; nxt.mem_r_en = 1'b1; end
        CLS_ST:  begin nxt.mem_w_en = 1'b1; nxt.st_val = rdata_b; end
        CLS_BNE: begin nxt.is_branch = 1'b1; nxt.st_val = rdata_b; end
        CLS_BEZ, CLS_JMP: nxt.is_branch = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush || hazard || !bus.instr_valid) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

  assign bus.EXE_CMD   = q.cmd;
  assign bus.val1      = q.val1;
  assign bus.val2      = q.val2;
  assign bus.st_val    = q.st_val;
  assign bus.dest      = q.dest;
  assign bus.WB_EN     = q.wb_en;
  assign bus.MEM_R_EN  = q.mem_r_en;
  assign bus.MEM_W_EN  = q.mem_w_en;
  assign bus.is_branch = q.is_branch;
  assign bus.exe_valid = q.valid;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if bus();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  id_exe_t exp_q[$];
  word_t   mregs [32];

  localparam id_exe_t BUB = '0;

  typedef struct {
    logic [3:0] cmd;
    logic       wb, mr, mw, br, valid;
    logic       use_r2;
    logic       st_rd;
  } sweep_t;

  sweep_t tbl [64];

  function automatic id_exe_t mk(input logic [3:0] c, input word_t v1, input word_t v2,
                                 input word_t st, input reg_idx_t d, input logic wb,
                                 input logic mr, input logic mw, input logic br);
    id_exe_t b;
    b = '0;
    b.cmd = c; b.val1 = v1; b.val2 = v2; b.st_val = st; b.dest = d;
    b.wb_en = wb; b.mem_r_en = mr; b.mem_w_en = mw; b.is_branch = br; b.valid = 1'b1;
    return b;
  endfunction

  function automatic word_t ri(input logic [5:0] op, input reg_idx_t d,
                               input reg_idx_t s1, input reg_idx_t s2);
    return {op, d, s1, s2, 11'd0};
  endfunction

  function automatic word_t ii(input logic [5:0] op, input reg_idx_t d,
                               input reg_idx_t s1, input logic [15:0] imm);
    return {op, d, s1, imm};
  endfunction

  // One decode cycle: drive, check the combinational stall, queue the
  // expected bundle, then pop and compare it after the edge.
  task automatic step(input logic r, input logic iv, input word_t ins, input logic fl,
                      input logic wbe, input reg_idx_t wbd, input word_t wbv,
                      input reg_idx_t ed, input logic ee, input reg_idx_t md, input logic me,
                      input logic exp_stall, input id_exe_t exp, input string name);
    id_exe_t g, e;
    rst = r; bus.instr_valid = iv; bus.instr = ins; bus.flush = fl;
    bus.wb_en = wbe; bus.wb_dest = wbd; bus.wb_value = wbv;
    bus.exe_dest = ed; bus.exe_wb_en = ee; bus.mem_dest = md; bus.mem_wb_en = me;
    #1;
    tests++;
    if (bus.hazard_stall !== exp_stall) begin
      fails++;
      $display("FAIL %s stall: got %b want %b", name, bus.hazard_stall, exp_stall);
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (wbe && wbd != 5'd0) mregs[wbd] = wbv;
    g.cmd = bus.EXE_CMD; g.val1 = bus.val1; g.val2 = bus.val2; g.st_val = bus.st_val;
    g.dest = bus.dest; g.wb_en = bus.WB_EN; g.mem_r_en = bus.MEM_R_EN;
    g.mem_w_en = bus.MEM_W_EN; g.is_branch = bus.is_branch; g.valid = bus.exe_valid;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: got empty queue want one entry", name);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        fails++;
        $display("FAIL %s bundle: got %h want %h", name, g, e);
      end
    end
  endtask

  initial begin
    id_exe_t e;
    word_t   ins;

    // Sweep table: {cmd, wb, mr, mw, br, valid, use_r2, st_rd}
    for (int i = 0; i < 64; i++) tbl[i] = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'd0, 1, 0, 0, 0, 1, 1, 0};
    tbl[3]  = '{4'd1, 1, 0, 0, 0, 1, 1, 0};
    tbl[5]  = '{4'd2, 1, 0, 0, 0, 1, 1, 0};
    tbl[6]  = '{4'd3, 1, 0, 0, 0, 1, 1, 0};
    tbl[7]  = '{4'd4, 1, 0, 0, 0, 1, 1, 0};
    tbl[8]  = '{4'd5, 1, 0, 0, 0, 1, 1, 0};
    tbl[9]  = '{4'd6, 1, 0, 0, 0, 1, 1, 0};
    tbl[10] = '{4'd7, 1, 0, 0, 0, 1, 1, 0};
    tbl[11] = '{4'd9, 1, 0, 0, 0, 1, 1, 0};
    tbl[12] = '{4'd8, 1, 0, 0, 0, 1, 1, 0};
    tbl[32] = '{4'd0, 1, 0, 0, 0, 1, 0, 0};
    tbl[33] = '{4'd1, 1, 0, 0, 0, 1, 0, 0};
    tbl[36] = '{4'd0, 1, 1, 0, 0, 1, 0, 0};
    tbl[37] = '{4'd0, 0, 0, 1, 0, 1, 0, 1};
    tbl[40] = '{4'd0, 0, 0, 0, 1, 1, 0, 0};
    tbl[41] = '{4'd0, 0, 0, 0, 1, 1, 0, 1};
    tbl[42] = '{4'd0, 0, 0, 0, 1, 1, 0, 0};

    mregs[0] = '0;
    rst = 1'b1;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_dest = '0; bus.wb_value = '0;
    bus.exe_dest = '0; bus.exe_wb_en = 1'b0; bus.mem_dest = '0; bus.mem_wb_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset: hazard inputs present but stall masked, outputs zero
    step(1, 1, ri(6'd1, 5'd4, 5'd1, 5'd1), 0, 0, 0, 0, 5'd1, 1, 0, 0, 0, BUB, "reset");

    step(0, 1, ii(6'd32, 5'd1, 5'd0, 16'd5), 0, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(4'd0, 0, 32'd5, 0, 5'd1, 1, 0, 0, 0), "addi_r1");
    step(0, 0, '0, 0, 1, 5'd1, 32'd5, 0, 0, 0, 0, 0, BUB, "wb_r1");
    step(0, 1, ri(6'd3, 5'd3, 5'd2, 5'd2), 0, 1, 5'd2, 32'd7, 0, 0, 0, 0, 0,
         mk(4'd1, 32'd7, 32'd7, 0, 5'd3, 1, 0, 0, 0), "wb_bypass_sub");

    // Two-cycle hazard: EXE then MEM, then issue, no duplicate
    step(0, 1, ri(6'd1, 5'd4, 5'd1, 5'd1), 0, 0, 0, 0, 5'd1, 1, 0, 0, 1, BUB, "haz_exe");
    step(0, 1, ri(6'd1, 5'd4, 5'd1, 5'd1), 0, 0, 0, 0, 0, 0, 5'd1, 1, 1, BUB, "haz_mem");
    step(0, 1, ri(6'd1, 5'd4, 5'd1, 5'd1), 0, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(4'd0, 32'd5, 32'd5, 0, 5'd4, 1, 0, 0, 0), "haz_issue");
    step(0, 0, ri(6'd1, 5'd4, 5'd1, 5'd1), 0, 0, 0, 0, 0, 0, 0, 0, 0, BUB, "no_dup");

    step(0, 1, ii(6'd32, 5'd5, 5'd0, 16'hFFFE), 0, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(4'd0, 0, 32'hFFFF_FFFE, 0, 5'd5, 1, 0, 0, 0), "imm_neg");
    step(0, 1, ri(6'd1, 5'd6, 5'd0, 5'd0), 0, 0, 0, 0, 5'd0, 1, 0, 0, 0,
         mk(4'd0, 0, 0, 0, 5'd6, 1, 0, 0, 0), "rs1_zero");
    step(0, 1, ri(6'd1, 5'd4, 5'd1, 5'd1), 1, 0, 0, 0, 5'd1, 1, 0, 0, 0, BUB, "flush_haz");

    // Writeback to a source while MEM also matches still stalls
    step(0, 1, ri(6'd1, 5'd7, 5'd1, 5'd2), 0, 1, 5'd1, 32'd9, 0, 0, 5'd1, 1, 1, BUB, "wb_mem_match");
    step(0, 1, ri(6'd1, 5'd7, 5'd1, 5'd2), 0, 1, 5'd1, 32'd11, 0, 0, 0, 0, 0,
         mk(4'd0, 32'd11, 32'd7, 0, 5'd7, 1, 0, 0, 0), "wb_same_reg");
    step(0, 1, ri(6'd1, 5'd8, 5'd1, 5'd1), 0, 0, 0, 0, 5'd1, 0, 5'd1, 0, 0,
         mk(4'd0, 32'd11, 32'd11, 0, 5'd8, 1, 0, 0, 0), "wb_en_off");

    // ST reads rd as a source
    step(0, 1, ii(6'd37, 5'd2, 5'd0, 16'd4), 0, 0, 0, 0, 5'd2, 1, 0, 0, 1, BUB, "st_rd_haz");
    step(0, 1, ii(6'd37, 5'd2, 5'd0, 16'd4), 0, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(4'd0, 0, 32'd4, 32'd7, 5'd2, 0, 0, 1, 0), "st_issue");
    step(0, 1, ii(6'd42, 5'd0, 5'd1, 16'h0010), 0, 0, 0, 0, 5'd1, 1, 0, 0, 0,
         mk(4'd0, 32'd11, 32'h10, 0, 5'd0, 0, 0, 0, 1), "jmp_nohaz");

    // Reset during a stall
    step(0, 1, ri(6'd1, 5'd4, 5'd1, 5'd1), 0, 0, 0, 0, 5'd1, 1, 0, 0, 1, BUB, "pre_rst_stall");
    step(1, 1, ri(6'd1, 5'd4, 5'd1, 5'd1), 0, 0, 0, 0, 5'd1, 1, 0, 0, 0, BUB, "rst_mid_stall");
    step(0, 1, ri(6'd1, 5'd4, 5'd1, 5'd1), 0, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(4'd0, 32'd11, 32'd11, 0, 5'd4, 1, 0, 0, 0), "rst_release");

    // Preload distinct register values, then sweep every opcode
    for (int i = 1; i < 32; i++) begin
      step(0, 0, '0, 0, 1, 5'(i), 32'hA500_0000 + 32'(i) * 32'h0001_0203,
           0, 0, 0, 0, 0, BUB, "preload");
    end
    for (int op = 0; op < 64; op++) begin
      ins = {6'(op), 5'd5, 5'd6, 16'hB801};
      if (tbl[op].valid) begin
        e = mk(tbl[op].cmd, mregs[6], tbl[op].use_r2 ? mregs[23] : 32'hFFFF_B801,
               tbl[op].st_rd ? mregs[5] : 32'd0, 5'd5,
               tbl[op].wb, tbl[op].mr, tbl[op].mw, tbl[op].br);
      end else begin
        e = BUB;
      end
      step(0, 1, ins, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, $sformatf("opcode_%0d", op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
